aes_ctr_feeder: RTL
===================

Name: aes_ctr_feeder

Overview:
- Upstream stage of the pipelined AES encryptor. Produces counter-mode input blocks {nonce, ctr} on the encryptor's data-ready/data-in interface at up to one block per cycle.
- Bounds outstanding blocks with a credit counter, because the encryptor has no backpressure and the downstream output buffer has finite depth.
- Tracks returned blocks (encryptor data-valid) so the block knows when a job has fully drained.

Parameters:
- CREDITS, 16, downstream buffer depth = maximum blocks issued but not yet released by the consumer (≥1, ≤255).
- LEN_W, 32, width of job length n_blocks.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job request; accepted only in IDLE.
- nonce  in  96  upper 96 bits of every block; sampled on accepted start.
- ctr_init  in  32  first counter value; sampled on accepted start.
- n_blocks  in  LEN_W  blocks in job; sampled on accepted start.
- abort  in  1  stop issuing new blocks; in-flight blocks still drain.
- dvld_in  in  1  encryptor output valid (one returned block).
- credit_ret  in  1  consumer popped one block from downstream buffer.
- drdy  out  1  to encryptor data-ready; one-cycle pulse per issued block.
- din  out  128  to encryptor data-in = {nonce_q, ctr_q}; valid when drdy=1.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when a job completes or finishes draining after abort.
- err  out  1  sticky; set on credit overflow or on dvld_in with nothing in flight.

Behaviour:
- Reset (async, RSTn=0): state=IDLE; drdy=0, din=0, busy=0, done=0, err=0; credit_cnt=CREDITS, inflight=0, remaining=0, ctr_q=0, nonce_q=0. Reset mid-job discards everything with no done pulse. err clears only on reset.
- All outputs are registered.
- IDLE:
  - start=1 latches nonce, ctr_init, n_blocks and moves to RUN (n_blocks≠0) or DRAIN (n_blocks=0).
  - Latency: start at cycle t produces first drdy at t+1.
- RUN, each cycle:
  - issue = (remaining≠0) & (credit_cnt≠0) & ~abort.
  - On issue: drdy=1, din={nonce_q, ctr_q}; ctr_q increments mod 2^32 (FFFFFFFF → 00000000; nonce is not carried into); remaining decrements; inflight increments.
  - With no credit stall, blocks issue back-to-back, one per cycle.
  - Next state is DRAIN when remaining reaches 0 or abort=1.
- DRAIN: no issue. When inflight=0, pulse done for one cycle, clear busy, go to IDLE in the same cycle. done is therefore one cycle after the last dvld_in.
- n_blocks=0: start at t gives done at t+2 (IDLE→DRAIN→IDLE) and no drdy.
- Credit counter (0..CREDITS):
  - issue decrements, credit_ret increments; both in the same cycle leave it unchanged.
  - credit_ret while at CREDITS with no issue: sets err, count saturates.
  - credit_ret is honoured in every state, including IDLE.
- inflight counter (0..CREDITS):
  - Increments on issue, decrements on dvld_in; both in the same cycle leave it unchanged.
  - dvld_in with inflight=0: sets err, counter stays 0.
- start while busy: ignored, no error.
- abort in IDLE: ignored.
- abort is level-sensitive in RUN; one cycle is enough to end the job.

Decomposition:
- Shared package crg_pkg:
  - typedef aes_block_t (logic[127:0]).
  - NONCE_W=96, CTR_W=32.
  - typedef enum feeder_state_t {IDLE, RUN, DRAIN}.
- One sub-module is natural: up_down_sat_cnt (parameter MAX, inc/dec inputs, simultaneous inc+dec = hold, overflow/underflow flags). Instantiate it twice, for credit_cnt and inflight.

Test Plan:
- Back-to-back job: CREDITS=16, nonce=0, ctr_init=0, n_blocks=3, credit_ret tied to dvld_in → drdy at t+1..t+3 with din=0,1,2; done one cycle after the third dvld_in; err=0.
- Credit stall: CREDITS=4, n_blocks=10, no credit_ret → exactly 4 drdy pulses, then idle. Then one credit_ret per 5 cycles → one issue per return; 10 blocks total; done after the final dvld_in.
- Wrap: ctr_init=32'hFFFF_FFFE, nonce=96'hA5..A5, n_blocks=4 → din low words FFFFFFFE, FFFFFFFF, 00000000, 00000001; din high 96 bits unchanged.
- Abort: n_blocks=100, abort pulsed after 5 issues → no further drdy, busy held until 5 dvld_in are seen, then one done.
- Edge cases:
  - n_blocks=0 → done at t+2, no drdy.
  - start during RUN → ignored.
  - dvld_in in IDLE → err=1 and stays 1 until RSTn.
- Async reset mid-job: RSTn low for 3 ns between clock edges during RUN → drdy, busy, done drop immediately; after release, a new job runs normally from the newly latched ctr_init.

Source files
------------

// File: rtl/crg_pkg.sv
// Shared types and widths for the AES counter-mode feeder.
package crg_pkg;

   localparam int NONCE_W = 96;
   localparam int CTR_W   = 32;

   typedef logic [127:0] aes_block_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/up_down_sat_cnt.sv
// Saturating up/down counter bounded to 0..MAX. Simultaneous inc and dec hold the count;
// a blocked step raises a one-cycle overflow/underflow flag.
module up_down_sat_cnt #(
   parameter int MAX     = 16,
   parameter int RST_VAL = 0,
   parameter int W       = $clog2(MAX + 1)
) (
   input  logic         CLK,
   input  logic         RSTn,
   input  logic         i_inc,
   input  logic         i_dec,
   output logic [W-1:0] o_cnt,
   output logic [W-1:0] o_nxt,
   output logic         o_ovf,
   output logic         o_unf
);

   logic [W-1:0] r_cnt;
   logic [W-1:0] w_nxt;

   always_comb begin
      w_nxt = r_cnt;
      o_ovf = 1'b0;
      o_unf = 1'b0;
      if (i_inc && !i_dec) begin
         if (r_cnt == W'(MAX)) o_ovf = 1'b1;
         else                  w_nxt = r_cnt + 1'b1;
      end else if (i_dec && !i_inc) begin
         if (r_cnt == '0) o_unf = 1'b1;
         else             w_nxt = r_cnt - 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) r_cnt <= W'(RST_VAL);
      else       r_cnt <= w_nxt;
   end

   assign o_cnt = r_cnt;
   assign o_nxt = w_nxt;

endmodule

// File: rtl/aes_ctr_feeder.sv
// Counter-mode block feeder for the pipelined AES core: issues {nonce, ctr} blocks under
// a credit limit and tracks returned blocks so it knows when a job has drained.
module aes_ctr_feeder
   import crg_pkg::*;
#(
   parameter int CREDITS = 16,
   parameter int LEN_W   = 32
) (
   input  logic               CLK,
   input  logic               RSTn,
   input  logic               start,
   input  logic [NONCE_W-1:0] nonce,
   input  logic [CTR_W-1:0]   ctr_init,
   input  logic [LEN_W-1:0]   n_blocks,
   input  logic               abort,
   input  logic               dvld_in,
   input  logic               credit_ret,
   output logic               drdy,
   output aes_block_t         din,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int CNT_W = $clog2(CREDITS + 1);

   feeder_state_t      r_state, w_state_nxt;
   logic [NONCE_W-1:0] r_nonce, w_nonce_eff;
   logic [CTR_W-1:0]   r_ctr, w_ctr_eff;
   logic [LEN_W-1:0]   r_rem, w_rem_eff, w_rem_nxt;
   logic               w_accept, w_issue, w_done;
   logic [CNT_W-1:0]   w_credit, w_credit_nxt, w_inflight, w_inflight_nxt;
   logic               w_credit_ovf, w_credit_unf, w_infl_ovf, w_infl_unf;
   logic               w_unused;

   // The first block goes out on the accepting edge, so job parameters bypass the registers.
   always_comb begin
      w_accept    = (r_state == IDLE) && start;
      w_nonce_eff = w_accept ? nonce    : r_nonce;
      w_ctr_eff   = w_accept ? ctr_init : r_ctr;
      w_rem_eff   = w_accept ? n_blocks : r_rem;
      w_issue     = (w_accept || ((r_state == RUN) && !abort)) &&
                    (w_rem_eff != '0) && (w_credit != '0);
      w_rem_nxt   = w_issue ? (w_rem_eff - 1'b1) : w_rem_eff;
      w_done      = (r_state == DRAIN) && (w_inflight_nxt == '0);
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = (w_rem_nxt == '0) ? DRAIN : RUN;
         RUN:     if (abort || (w_rem_nxt == '0)) w_state_nxt = DRAIN;
         DRAIN:   if (w_done) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state <= IDLE;
         r_nonce <= '0;
         r_ctr   <= '0;
         r_rem   <= '0;
         drdy    <= 1'b0;
         din     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_nonce <= w_nonce_eff;
         r_ctr   <= w_issue ? (w_ctr_eff + 1'b1) : w_ctr_eff;
         r_rem   <= w_rem_nxt;
         drdy    <= w_issue;
         if (w_issue) din <= {w_nonce_eff, w_ctr_eff};
         busy    <= (w_state_nxt != IDLE);
         done    <= w_done;
         if (w_credit_ovf || w_infl_unf) err <= 1'b1;
      end
   end

   up_down_sat_cnt #(.MAX(CREDITS), .RST_VAL(CREDITS), .W(CNT_W)) u_credit_cnt (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .i_inc (credit_ret),
      .i_dec (w_issue),
      .o_cnt (w_credit),
      .o_nxt (w_credit_nxt),
      .o_ovf (w_credit_ovf),
      .o_unf (w_credit_unf)
   );

   up_down_sat_cnt #(.MAX(CREDITS), .RST_VAL(0), .W(CNT_W)) u_inflight_cnt (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .i_inc (w_issue),
      .i_dec (dvld_in),
      .o_cnt (w_inflight),
      .o_nxt (w_inflight_nxt),
      .o_ovf (w_infl_ovf),
      .o_unf (w_infl_unf)
   );

   // Issue is gated by credit, so credit underflow and in-flight overflow cannot occur.
   assign w_unused = &{1'b0, w_credit_nxt, w_credit_unf, w_inflight, w_infl_ovf};

endmodule
